// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared widths, FSM encoding and port ids for the data-memory controller
package dmem_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  typedef enum logic [1:0] {DMC_IDLE, DMC_ACCESS, DMC_MERGE, DMC_DONE} dmc_state_t;
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: one requester port of the data-memory controller
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;
  logic req;
  logic we;
  logic [BE_W-1:0] be;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic ack;
  logic [WORD_W-1:0] rdata;
  logic busy;
  modport master (output req, we, be, addr, wdata, input ack, rdata, busy);
  modport slave (input req, we, be, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: per-lane select between the old memory word and new write data
module dmem_byte_merge
  import dmem_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] merged
);
  for (genvar b = 0; b < BE_W; b++) begin : g_lane
    assign merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin two-port arbiter that sequences accesses onto a single-ported
// data memory, turning partial stores into read-modify-write pairs
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  dmem_ctrl_if.slave        p0,
  dmem_ctrl_if.slave        p1,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  dmc_state_t state;
  logic port, last, we, grant, full, partial, active;
  logic [BE_W-1:0] be;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata, merge_q, rdata0, rdata1, merged;
  assign grant = (p0.req && p1.req) ? ~last : p1.req;
  assign full = we && be == 4'hF;
  assign partial = we && be != 4'h0 && !full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMC_IDLE;
      last <= PORT_DMA;
      port <= PORT_CPU;
      we <= 1'b0;
      be <= '0;
      addr <= '0;
      wdata <= ZERO_WORD;
      merge_q <= ZERO_WORD;
      rdata0 <= ZERO_WORD;
      rdata1 <= ZERO_WORD;
    end else begin
      case (state)
        DMC_IDLE: if (p0.req || p1.req) begin
          port <= grant;
          last <= grant;
          we <= grant ? p1.we : p0.we;
          be <= grant ? p1.be : p0.be;
          addr <= grant ? p1.addr : p0.addr;
          wdata <= grant ? p1.wdata : p0.wdata;
          state <= DMC_ACCESS;
        end
        DMC_ACCESS: begin
          if (!full) merge_q <= mem_rdata;
          if (!we && port == PORT_CPU) rdata0 <= mem_rdata;
          if (!we && port == PORT_DMA) rdata1 <= mem_rdata;
          state <= partial ? DMC_MERGE : DMC_DONE;
        end
        DMC_MERGE: state <= DMC_DONE;
        DMC_DONE: state <= DMC_IDLE;
      endcase
    end
  end
  dmem_byte_merge u_merge (.old_word(merge_q), .new_word(wdata), .be(be), .merged(merged));
  // memory pins decode from registered state so reset blanks them immediately
  assign active = state == DMC_ACCESS || state == DMC_MERGE;
  assign mem_ce = active;
  assign mem_we = state == DMC_MERGE || (state == DMC_ACCESS && full);
  assign mem_addr = active ? addr : '0;
  assign mem_wdata = state == DMC_MERGE ? merged : (state == DMC_ACCESS && full) ? wdata : ZERO_WORD;
  assign p0.ack = state == DMC_DONE && port == PORT_CPU;
  assign p1.ack = state == DMC_DONE && port == PORT_DMA;
  assign p0.busy = state != DMC_IDLE && port == PORT_CPU;
  assign p1.busy = state != DMC_IDLE && port == PORT_DMA;
  assign p0.rdata = rdata0;
  assign p1.rdata = rdata1;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector table, corner sequences and randomized run against a
// transaction-level model of the two-port data-memory controller
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;
  typedef struct {
    int port; logic we; logic [3:0] be; logic [31:0] addr, wdata; logic drop;
    logic [31:0] exp_rd; int exp_lat, exp_pulses; logic [31:0] exp_ww;
  } vec_t;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr, wdata;} txn_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  dmem_ctrl_if p0();
  dmem_ctrl_if p1();
  logic mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic pre_en = 0;
  logic [5:0] pre_idx = 0;
  logic [31:0] pre_data = 0;
  int total = 0, bad = 0;
  dmem_ctrl dut (.clk(clk), .rst_n(rst_n), .p0(p0), .p1(p1), .mem_ce(mem_ce), .mem_we(mem_we),
                 .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  assign mem_rdata = mem[mem_addr[7:2]];
  wire addr_ok = !mem_ce || (mem_addr[31:8] == 0 && mem_addr[1:0] == 0);
  always @(posedge clk)
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_ce && mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin p0.req = req; p0.we = we; p0.be = be; p0.addr = addr; p0.wdata = wdata; end
    else begin p1.req = req; p1.we = we; p1.be = be; p1.addr = addr; p1.wdata = wdata; end
  endtask

  task automatic set_req(input int p, input logic r);
    if (p == 0) p0.req = r; else p1.req = r;
  endtask

  function automatic logic ack_of(input int p); return p == 0 ? p0.ack : p1.ack; endfunction
  function automatic logic [31:0] rdata_of(input int p); return p == 0 ? p0.rdata : p1.rdata; endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    pre_en = 1; pre_idx = idx[5:0]; pre_data = d;
    @(posedge clk); #1;
    pre_en = 0;
  endtask

  task automatic do_access(input vec_t v, output int lat, output int pulses, output int ce_n,
                           output logic [31:0] ww, output logic [31:0] rd);
    lat = 0; pulses = 0; ce_n = 0; ww = 0; rd = 0;
    set_port(v.port, 1, v.we, v.be, v.addr, v.wdata);
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (v.drop) set_req(v.port, 0);
      if (mem_ce) ce_n++;
      if (mem_we) begin pulses++; ww = mem_wdata; end
      if (!addr_ok) chk("mem addr align", mem_addr, v.addr);
      if (ack_of(1 - v.port)) chk("other port ack", 1, 0);
      if (ack_of(v.port)) begin lat = n; rd = rdata_of(v.port); set_req(v.port, 0); end
    end
    set_req(v.port, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[9];
    txn_t pend[2];
    bit has[2];
    logic [31:0] mm[8];
    logic [31:0] exp_rd[2];
    logic [31:0] ww, rd;
    int lat, pulses, ce_n, a0, a1, first, g, grant_t, ack_at, idle_at, m_last, idx;
    bit active;
    tbl[0] = '{0, 0, 4'hF, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 0, 32'h0};
    tbl[1] = '{1, 1, 4'hF, 32'h20, 32'h12345678, 0, 32'h0,        2, 1, 32'h12345678};
    tbl[2] = '{0, 0, 4'hF, 32'h20, 32'h0,        0, 32'h12345678, 2, 0, 32'h0};
    tbl[3] = '{0, 1, 4'h4, 32'h20, 32'h00AB0000, 0, 32'h12345678, 3, 1, 32'h12AB5678};
    tbl[4] = '{1, 0, 4'h0, 32'h20, 32'h0,        0, 32'h12AB5678, 2, 0, 32'h0};
    tbl[5] = '{0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 0, 32'h12345678, 2, 0, 32'h0};
    tbl[6] = '{1, 0, 4'hF, 32'h20, 32'h0,        1, 32'h12AB5678, 2, 0, 32'h0};
    tbl[7] = '{1, 1, 4'h9, 32'h10, 32'hAA0000BB, 0, 32'h12AB5678, 3, 1, 32'hAAADBEBB};
    tbl[8] = '{0, 0, 4'hF, 32'h10, 32'h0,        0, 32'hAAADBEBB, 2, 0, 32'h0};
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    preload(4, 32'hDEADBEEF);
    chk("rst ack0", p0.ack, 0);
    chk("rst ack1", p1.ack, 0);
    chk("rst busy0", p0.busy, 0);
    chk("rst busy1", p1.busy, 0);
    chk("rst rdata0", p0.rdata, 0);
    chk("rst rdata1", p1.rdata, 0);
    chk("rst mem_ce", mem_ce, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    rst_n = 1;
    foreach (tbl[i]) begin
      do_access(tbl[i], lat, pulses, ce_n, ww, rd);
      chk($sformatf("v%0d latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("v%0d we pulses", i), pulses, tbl[i].exp_pulses);
      chk($sformatf("v%0d ce cycles", i), ce_n, tbl[i].exp_lat - 1);
      chk($sformatf("v%0d rdata", i), rd, tbl[i].exp_rd);
      if (tbl[i].exp_pulses == 1) chk($sformatf("v%0d mem_wdata", i), ww, tbl[i].exp_ww);
    end
    // simultaneous requests straight out of reset: port 0 first, then port 1
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    set_port(0, 1, 0, 4'hF, 32'h10, 0);
    set_port(1, 1, 0, 4'hF, 32'h20, 0);
    a0 = 0; a1 = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (p0.ack && a0 == 0) begin a0 = n; p0.req = 0; end
      if (p1.ack && a1 == 0) begin a1 = n; p1.req = 0; end
    end
    chk("contend ack0 cycle", a0, 2);
    chk("contend ack1 cycle", a1, 5);
    chk("contend rdata0", p0.rdata, 32'hAAADBEBB);
    chk("contend rdata1", p1.rdata, 32'h12AB5678);
    for (int k = 0; k < 4; k++) begin
      set_port(0, 1, 0, 4'hF, 32'h10, 0);
      set_port(1, 1, 0, 4'hF, 32'h20, 0);
      first = -1;
      for (int n = 1; n <= 8 && first < 0; n++) begin
        @(posedge clk); #1;
        if (p0.ack) first = 0; else if (p1.ack) first = 1;
      end
      p0.req = 0; p1.req = 0;
      chk($sformatf("alternate %0d", k), first, k % 2);
    end
    // reset lands in the MERGE cycle of a partial write
    @(posedge clk); #1;
    set_port(0, 1, 1, 4'h1, 32'h20, 32'h000000FF);
    @(posedge clk); #1;
    chk("rmw access mem_we", mem_we, 0);
    @(posedge clk); #1;
    chk("rmw merge mem_we", mem_we, 1);
    chk("rmw merge wdata", mem_wdata, 32'h12AB56FF);
    rst_n = 0;
    #1;
    chk("rmw rst mem_ce", mem_ce, 0);
    chk("rmw rst busy0", p0.busy, 0);
    p0.req = 0;
    @(posedge clk); #1;
    chk("rmw rst ack0", p0.ack, 0);
    rst_n = 1;
    do_access('{1, 0, 4'hF, 32'h20, 32'h0, 0, 32'h0, 0, 0, 32'h0}, lat, pulses, ce_n, ww, rd);
    chk("rmw abort word", rd, 32'h12345678 & 32'h0 | 32'h12AB5678);
    chk("rmw abort idle lat", lat, 2);
    // randomized traffic against a transaction-level scheduler model
    rst_n = 0;
    for (int i = 0; i < 8; i++) begin
      mm[i] = $urandom;
      preload(i, mm[i]);
    end
    rst_n = 1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    has[0] = 0; has[1] = 0;
    active = 0; idle_at = 0; m_last = 1; g = 0; grant_t = 0; ack_at = 0;
    for (int t = 0; t < 800; t++) begin
      chk("rnd ack0", p0.ack, active && ack_at == t && g == 0);
      chk("rnd ack1", p1.ack, active && ack_at == t && g == 1);
      chk("rnd busy0", p0.busy, active && t > grant_t && g == 0);
      chk("rnd busy1", p1.busy, active && t > grant_t && g == 1);
      if (active && ack_at == t) begin
        idx = int'(pend[g].addr[4:2]);
        if (!pend[g].we) exp_rd[g] = mm[idx];
        else mm[idx] = (mm[idx] & ~lane_mask(pend[g].be)) | (pend[g].wdata & lane_mask(pend[g].be));
        has[g] = 0;
        set_req(g, 0);
        active = 0;
      end
      chk("rnd rdata0", p0.rdata, exp_rd[0]);
      chk("rnd rdata1", p1.rdata, exp_rd[1]);
      for (int p = 0; p < 2; p++)
        if (!has[p] && $urandom_range(0, 1) == 1) begin
          pend[p].we = 1'($urandom_range(0, 1));
          pend[p].be = $urandom_range(0, 3) == 0 ? 4'hF : $urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom);
          pend[p].addr = 32'($urandom_range(0, 7)) << 2;
          pend[p].wdata = $urandom;
          has[p] = 1;
          set_port(p, 1, pend[p].we, pend[p].be, pend[p].addr, pend[p].wdata);
        end
      if (!active && t >= idle_at && (has[0] || has[1])) begin
        g = (has[0] && has[1]) ? 1 - m_last : (has[1] ? 1 : 0);
        m_last = g;
        active = 1;
        grant_t = t;
        ack_at = t + ((pend[g].we && pend[g].be != 4'h0 && pend[g].be != 4'hF) ? 3 : 2);
        idle_at = ack_at + 1;
      end
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
